// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// Holds the next-PC select encodings (also decoded by the control unit),
// the canonical NOP word and the fetch FSM state encodings.
package instruction_fetch_unit_pkg;

    // Next-PC select, as driven by the control unit
    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_B    = 2'd1,
        NPC_JAL  = 2'd2,
        NPC_JALR = 2'd3
    } npc_op_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_TRAP  = 2'd3
    } ifu_state_e;

    // Instruction addresses must be word aligned
    function automatic logic isMisaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Purely combinational next-PC selection plus misalignment detection.
// Ports:
//   Pc_i           current program counter
//   NpcOperation_i next-PC select (npc_op_e encoding)
//   BranchTaken_i  branch compare result, only meaningful for NPC_B
//   Immediate_i    sign-extended immediate
//   JalrTarget_i   rs1+imm from the ALU
//   NextPc_o       selected next PC (mod 2^32)
//   Misaligned_o   NextPc_o is not word aligned
module next_pc_calc
    import instruction_fetch_unit_pkg::*;
(
    input  logic [31:0] Pc_i,
    input  logic [1:0]  NpcOperation_i,
    input  logic        BranchTaken_i,
    input  logic [31:0] Immediate_i,
    input  logic [31:0] JalrTarget_i,
    output logic [31:0] NextPc_o,
    output logic        Misaligned_o
);

    logic [31:0] pcPlus4;
    logic [31:0] pcPlusImm;

    assign pcPlus4   = Pc_i + 32'd4;
    assign pcPlusImm = Pc_i + Immediate_i;

    // JALR clears bit 0 of the target; a not-taken branch falls through
    always_comb begin
        NextPc_o = pcPlus4;
        unique case (npc_op_e'(NpcOperation_i))
            NPC_PC4:  NextPc_o = pcPlus4;
            NPC_B:    NextPc_o = BranchTaken_i ? pcPlusImm : pcPlus4;
            NPC_JAL:  NextPc_o = pcPlusImm;
            NPC_JALR: NextPc_o = JalrTarget_i & ~32'h1;
            default:  NextPc_o = pcPlus4;
        endcase
    end

    assign Misaligned_o = isMisaligned(NextPc_o);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from IROM over a
// request/valid handshake and holds the fetched instruction until execute
// accepts it with Advance.
// Ports:
//   Clock_i, Reset_i          clock, synchronous active-high reset
//   NpcOperation_i            next-PC select from the control unit
//   BranchTaken_i             branch compare result
//   Immediate_i, JalrTarget_i next-PC operands
//   Advance_i                 execute accepts the current instruction
//   IromRequest_o             fetch request
//   IromAddress_o             IROM word address (PC[IROM_AW+1:2])
//   IromValid_i, IromData_i   IROM response
//   Instruction_o             current instruction
//   InstructionValid_o        Instruction_o / ProgramCounter_o are valid
//   ProgramCounter_o          PC of the current instruction
//   PcPlus4_o                 ProgramCounter_o + 4
//   Misaligned_o              sticky misaligned-target flag
//   RetireCount_o             number of accepted Advances
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IROM_AW  = 14
) (
    input  logic               Clock_i,
    input  logic               Reset_i,
    input  logic [1:0]         NpcOperation_i,
    input  logic               BranchTaken_i,
    input  logic [31:0]        Immediate_i,
    input  logic [31:0]        JalrTarget_i,
    input  logic               Advance_i,
    output logic               IromRequest_o,
    output logic [IROM_AW-1:0] IromAddress_o,
    input  logic               IromValid_i,
    input  logic [31:0]        IromData_i,
    output logic [31:0]        Instruction_o,
    output logic               InstructionValid_o,
    output logic [31:0]        ProgramCounter_o,
    output logic [31:0]        PcPlus4_o,
    output logic               Misaligned_o,
    output logic [31:0]        RetireCount_o
);

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instrValid_q;
    logic        request_q;
    logic        misaligned_q;
    logic [31:0] retireCount_q;

    logic [31:0] nextPc_d;
    logic        nextMisaligned_d;

    next_pc_calc u_next_pc_calc (
        .Pc_i           (pc_q),
        .NpcOperation_i (NpcOperation_i),
        .BranchTaken_i  (BranchTaken_i),
        .Immediate_i    (Immediate_i),
        .JalrTarget_i   (JalrTarget_i),
        .NextPc_o       (nextPc_d),
        .Misaligned_o   (nextMisaligned_d)
    );

    // Fetch FSM. IromRequest is registered, so it is set on the edge that
    // enters FETCH and cleared on the edge that leaves it. BOOT ignores
    // IromValid so a response left over from before a reset is dropped.
    // A misaligned target keeps the old PC but still counts the retire.
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instrValid_q  <= 1'b0;
            request_q     <= 1'b0;
            misaligned_q  <= 1'b0;
            retireCount_q <= 32'd0;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_q   <= ST_FETCH;
                    request_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (IromValid_i) begin
                        instr_q      <= IromData_i;
                        instrValid_q <= 1'b1;
                        request_q    <= 1'b0;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (Advance_i) begin
                        instrValid_q  <= 1'b0;
                        retireCount_q <= retireCount_q + 32'd1;
                        if (nextMisaligned_d) begin
                            misaligned_q <= 1'b1;
                            state_q      <= ST_TRAP;
                        end else begin
                            pc_q      <= nextPc_d;
                            request_q <= 1'b1;
                            state_q   <= ST_FETCH;
                        end
                    end
                end
                ST_TRAP: begin
                    request_q    <= 1'b0;
                    instrValid_q <= 1'b0;
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign IromRequest_o      = request_q;
    assign IromAddress_o      = pc_q[IROM_AW+1:2];
    assign Instruction_o      = instr_q;
    assign InstructionValid_o = instrValid_q;
    assign ProgramCounter_o   = pc_q;
    assign PcPlus4_o          = pc_q + 32'd4;
    assign Misaligned_o       = misaligned_q;
    assign RetireCount_o      = retireCount_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. Inputs change 1 ns after
// each rising edge and outputs are checked at the same point.
module tb_instruction_fetch_unit;

   localparam logic [1:0] OP_PC4  = 2'd0;
   localparam logic [1:0] OP_B    = 2'd1;
   localparam logic [1:0] OP_JAL  = 2'd2;
   localparam logic [1:0] OP_JALR = 2'd3;

   logic        clock;
   logic        reset;
   logic [1:0]  npcOperation;
   logic        branchTaken;
   logic [31:0] immediate;
   logic [31:0] jalrTarget;
   logic        advance;
   logic        iromRequest;
   logic [13:0] iromAddress;
   logic        iromValid;
   logic [31:0] iromData;
   logic [31:0] instruction;
   logic        instructionValid;
   logic [31:0] programCounter;
   logic [31:0] pcPlus4;
   logic        misaligned;
   logic [31:0] retireCount;

   logic        tieValid;
   logic        validDrv;
   logic [31:0] dataDrv;

   int checks = 0;
   int errors = 0;

   // Zero-latency IROM mode answers every request in the same cycle with a
   // word tagged by its address; otherwise the bench drives the response
   assign iromValid = tieValid ? iromRequest : validDrv;
   assign iromData  = tieValid ? (32'hA000_0000 | {18'b0, iromAddress}) : dataDrv;

   instruction_fetch_unit dut (
      .Clock_i            (clock),
      .Reset_i            (reset),
      .NpcOperation_i     (npcOperation),
      .BranchTaken_i      (branchTaken),
      .Immediate_i        (immediate),
      .JalrTarget_i       (jalrTarget),
      .Advance_i          (advance),
      .IromRequest_o      (iromRequest),
      .IromAddress_o      (iromAddress),
      .IromValid_i        (iromValid),
      .IromData_i         (iromData),
      .Instruction_o      (instruction),
      .InstructionValid_o (instructionValid),
      .ProgramCounter_o   (programCounter),
      .PcPlus4_o          (pcPlus4),
      .Misaligned_o       (misaligned),
      .RetireCount_o      (retireCount)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard bound on total run time
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed still running expected finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // From HOLD: accept the current instruction with the given next-PC
   // selection, then let the zero-latency IROM bring the core back to HOLD
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] imm, input logic taken,
                                input logic [31:0] target, input logic [31:0] expPc, input string tag);
      npcOperation = op;
      immediate    = imm;
      branchTaken  = taken;
      jalrTarget   = target;
      advance      = 1'b1;
      tick();
      advance = 1'b0;
      checkOutput({tag, "_pc"}, programCounter, expPc);
      checkOutput({tag, "_valid"}, {31'b0, instructionValid}, 32'd0);
      tick();
      checkOutput({tag, "_hold"}, {31'b0, instructionValid}, 32'd1);
   endtask

   initial begin
      reset        = 1'b1;
      npcOperation = OP_PC4;
      branchTaken  = 1'b0;
      immediate    = 32'd0;
      jalrTarget   = 32'd0;
      advance      = 1'b0;
      tieValid     = 1'b0;
      validDrv     = 1'b0;
      dataDrv      = 32'd0;

      // Reset values
      tick();
      tick();
      checkOutput("rst_req", {31'b0, iromRequest}, 32'd0);
      checkOutput("rst_valid", {31'b0, instructionValid}, 32'd0);
      checkOutput("rst_instr", instruction, 32'h0000_0013);
      checkOutput("rst_pc", programCounter, 32'd0);
      checkOutput("rst_retire", retireCount, 32'd0);
      checkOutput("rst_mis", {31'b0, misaligned}, 32'd0);

      // Zero-latency sequential fetch with Advance held high
      reset    = 1'b0;
      tieValid = 1'b1;
      advance  = 1'b1;
      tick();
      checkOutput("seq_boot_req", {31'b0, iromRequest}, 32'd1);
      checkOutput("seq_addr0", {18'b0, iromAddress}, 32'd0);
      checkOutput("seq_valid0", {31'b0, instructionValid}, 32'd0);
      tick();
      checkOutput("seq_hold0", {31'b0, instructionValid}, 32'd1);
      checkOutput("seq_instr0", instruction, 32'hA000_0000);
      checkOutput("seq_pc0", programCounter, 32'd0);
      checkOutput("seq_pc4_0", pcPlus4, 32'd4);
      tick();
      checkOutput("seq_fetch1_valid", {31'b0, instructionValid}, 32'd0);
      checkOutput("seq_fetch1_addr", {18'b0, iromAddress}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         checkOutput("seq_hold_valid", {31'b0, instructionValid}, 32'd1);
         checkOutput("seq_hold_instr", instruction, 32'hA000_0000 | i);
         checkOutput("seq_hold_pc", programCounter, 32'(4 * i));
         tick();
         checkOutput("seq_fetch_valid", {31'b0, instructionValid}, 32'd0);
         checkOutput("seq_fetch_addr", {18'b0, iromAddress}, 32'(i + 1));
      end
      checkOutput("seq_retire4", retireCount, 32'd4);
      checkOutput("seq_pc10", programCounter, 32'h10);
      advance = 1'b0;
      tick();
      checkOutput("seq_hold_pc10", programCounter, 32'h10);

      // Branch taken / not taken, JALR bit-0 clearing
      applyStimulus(OP_B, 32'hFFFF_FFF8, 1'b1, 32'd0, 32'h08, "b_taken");
      applyStimulus(OP_JAL, 32'h8, 1'b0, 32'd0, 32'h10, "jal_back");
      applyStimulus(OP_B, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'h14, "b_not_taken");
      applyStimulus(OP_JALR, 32'h0, 1'b0, 32'h0000_0101, 32'h100, "jalr");
      checkOutput("jalr_mis", {31'b0, misaligned}, 32'd0);
      applyStimulus(OP_JALR, 32'h0, 1'b0, 32'h0, 32'h0, "jalr_zero");
      checkOutput("pre_trap_retire", retireCount, 32'd9);

      // Misaligned JAL target traps without moving the PC
      npcOperation = OP_JAL;
      immediate    = 32'h6;
      advance      = 1'b1;
      tick();
      advance = 1'b0;
      checkOutput("trap_mis", {31'b0, misaligned}, 32'd1);
      checkOutput("trap_valid", {31'b0, instructionValid}, 32'd0);
      checkOutput("trap_pc", programCounter, 32'd0);
      checkOutput("trap_retire", retireCount, 32'd10);
      for (int i = 0; i < 10; i++) begin
         advance  = i[0];
         validDrv = 1'b1;
         tick();
         checkOutput("trap_req", {31'b0, iromRequest}, 32'd0);
      end
      advance = 1'b0;
      checkOutput("trap_retire_hold", retireCount, 32'd10);
      checkOutput("trap_mis_sticky", {31'b0, misaligned}, 32'd1);

      // Reset out of TRAP, then a 3-cycle IROM with changing data
      tieValid = 1'b0;
      validDrv = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("trap_rst_mis", {31'b0, misaligned}, 32'd0);
      tick();
      checkOutput("lat_retire0", retireCount, 32'd0);
      dataDrv = 32'h1111_1111;
      checkOutput("lat_addr_c1", {18'b0, iromAddress}, 32'd0);
      tick();
      dataDrv = 32'h2222_2222;
      checkOutput("lat_addr_c2", {18'b0, iromAddress}, 32'd0);
      checkOutput("lat_valid_c2", {31'b0, instructionValid}, 32'd0);
      tick();
      dataDrv  = 32'h3333_3333;
      validDrv = 1'b1;
      checkOutput("lat_addr_c3", {18'b0, iromAddress}, 32'd0);
      checkOutput("lat_req_c3", {31'b0, iromRequest}, 32'd1);
      tick();
      validDrv = 1'b0;
      dataDrv  = 32'h4444_4444;
      checkOutput("lat_instr", instruction, 32'h3333_3333);
      checkOutput("lat_valid", {31'b0, instructionValid}, 32'd1);

      // Reset in the middle of a fetch, stale response right after
      npcOperation = OP_PC4;
      advance      = 1'b1;
      tick();
      advance = 1'b0;
      checkOutput("mid_pc4", programCounter, 32'h4);
      tick();
      checkOutput("mid_req", {31'b0, iromRequest}, 32'd1);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      validDrv = 1'b1;
      dataDrv  = 32'hDEAD_BEEF;
      checkOutput("mid_rst_pc", programCounter, 32'd0);
      checkOutput("mid_rst_req", {31'b0, iromRequest}, 32'd0);
      checkOutput("mid_rst_retire", retireCount, 32'd0);
      tick();
      validDrv = 1'b0;
      checkOutput("stale_valid", {31'b0, instructionValid}, 32'd0);
      checkOutput("stale_instr", instruction, 32'h0000_0013);
      checkOutput("restart_req", {31'b0, iromRequest}, 32'd1);
      checkOutput("restart_addr", {18'b0, iromAddress}, 32'd0);
      dataDrv  = 32'hCAFE_0013;
      validDrv = 1'b1;
      tick();
      validDrv = 1'b0;
      checkOutput("restart_instr", instruction, 32'hCAFE_0013);
      checkOutput("restart_pc", programCounter, 32'd0);

      // PC wrap-around at the top of the address space
      tieValid = 1'b1;
      applyStimulus(OP_JAL, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'hFFFF_FFFC, "jal_top");
      checkOutput("top_pcplus4", pcPlus4, 32'd0);
      checkOutput("top_addr", {18'b0, iromAddress}, 32'h3FFF);
      applyStimulus(OP_PC4, 32'd0, 1'b0, 32'd0, 32'd0, "wrap");
      checkOutput("wrap_mis", {31'b0, misaligned}, 32'd0);
      checkOutput("wrap_retire", retireCount, 32'd2);

      // Advance while no instruction is valid has no effect
      npcOperation = OP_PC4;
      advance      = 1'b1;
      tick();
      tieValid = 1'b0;
      validDrv = 1'b0;
      checkOutput("adv_fetch_pc", programCounter, 32'h4);
      checkOutput("adv_fetch_retire", retireCount, 32'd3);
      tick();
      tick();
      advance = 1'b0;
      checkOutput("adv_invalid_retire", retireCount, 32'd3);
      checkOutput("adv_invalid_pc", programCounter, 32'h4);
      checkOutput("adv_invalid_valid", {31'b0, instructionValid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
